// File: rtl/pipe_stall_ctrl.sv
//==============================================================================
// Module      : pipe_stall_ctrl
// Description : Central hazard/stall controller for a 5-stage MIPS pipeline.
//               Drives hold/clear of the IF/ID, ID/EX, EX/MEM and MEM/WB
//               pipeline registers plus the PC hold. Hazards are resolved in
//               priority order: memory wait, mult/div, load-use, taken branch.
//               Also owns the mult/div busy sequencer and a stall-cycle
//               performance counter.
// Ports       : clk, rst_n                  clock / async active-low reset
//               id_rs, id_rt, id_uses_rt    source operands of the ID instr
//               id_branch_taken             branch resolved taken in ID
//               ex_memread, ex_rt           load in EX and its destination
//               ex_md_start                 EX instruction is mult/div
//               mem_wait                    memory not ready
//               pc_hold, *_hold, *_clear    pipeline register controls
//               md_busy, md_done            mult/div sequencer status
//               stall_cnt                   cycles with pc_hold=1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stall_ctrl #(
  parameter int REGW      = 5,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            id_branch_taken,
  input  logic            ex_memread,
  input  logic [REGW-1:0] ex_rt,
  input  logic            ex_md_start,
  input  logic            mem_wait,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            ifid_clear,
  output logic            idex_hold,
  output logic            idex_clear,
  output logic            exmem_hold,
  output logic            exmem_clear,
  output logic            memwb_hold,
  output logic            memwb_clear,
  output logic            md_busy,
  output logic            md_done,
  output logic [31:0]     stall_cnt
);

  localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] c_md_load = CW'(MD_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // With the minimum latency there are no BUSY cycles: start cycle then DONE.
  localparam state_t c_first_state = (MD_CYCLES > 2) ? ST_BUSY : ST_DONE;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_md_cnt, w_md_cnt_nxt;
  logic [31:0]   r_stall_cnt;
  logic          w_load_use;
  logic          w_md_stall;

  assign w_load_use = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // DONE is deliberately excluded: the held mult/div instruction leaves EX
  // that cycle, so its still-asserted ex_md_start must not restart it.
  assign w_md_stall = ((r_state == ST_IDLE) && ex_md_start) || (r_state == ST_BUSY);

  // Mult/div sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Mult/div next state; a memory wait freezes the whole sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    if (!mem_wait) begin
      case (r_state)
        ST_IDLE: begin
          if (ex_md_start) begin
            w_md_cnt_nxt = c_md_load;
            w_state_nxt  = c_first_state;
          end
        end
        ST_BUSY: begin
          // Counter reaches zero on the edge that enters DONE.
          w_md_cnt_nxt = r_md_cnt - 1'b1;
          if (r_md_cnt <= CW'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_md_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Hold/clear outputs, priority encoded.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_clear  = 1'b0;
    idex_hold   = 1'b0;
    idex_clear  = 1'b0;
    exmem_hold  = 1'b0;
    exmem_clear = 1'b0;
    memwb_hold  = 1'b0;
    memwb_clear = 1'b0;
    if (!rst_n) begin
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
      memwb_clear = 1'b1;
    end else if (mem_wait) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_hold = 1'b1;
    end else if (w_md_stall) begin
      // Front of pipe waits on the multiplier; a bubble goes into EX/MEM.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_clear = 1'b1;
    end else if (w_load_use) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_clear = 1'b1;
    end else if (id_branch_taken) begin
      ifid_clear = 1'b1;
    end
  end

  assign md_busy = (r_state == ST_BUSY);
  assign md_done = (r_state == ST_DONE);

  // Stall-cycle performance counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (pc_hold) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage MIPS pipeline; drives the hold/clear pins of every IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register, plus the PC hold.
- Resolves four hazard classes, highest priority first: memory wait, multi-cycle mult/div, load-use, taken branch.
- Owns the mult/div busy sequencer and a free-running stall-cycle performance counter.

Parameters:
- REGW, 5, register index width.
- MD_CYCLES, 32, mult/div latency in cycles; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  REGW  rs index of the instruction in ID.
- id_rt  in  REGW  rt index of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  REGW  load destination in EX.
- ex_md_start  in  1  EX instruction is mult/div.
- mem_wait  in  1  data/instruction memory not ready.
- pc_hold  out  1  hold PC.
- ifid_hold  out  1  hold IF/ID register.
- ifid_clear  out  1  clear IF/ID register.
- idex_hold  out  1  hold ID/EX register.
- idex_clear  out  1  clear ID/EX register.
- exmem_hold  out  1  hold EX/MEM register.
- exmem_clear  out  1  clear EX/MEM register.
- memwb_hold  out  1  hold MEM/WB register.
- memwb_clear  out  1  clear MEM/WB register.
- md_busy  out  1  mult/div in progress.
- md_done  out  1  mult/div result valid this cycle.
- stall_cnt  out  32  count of cycles with pc_hold=1.

Behaviour:
- Hold/clear outputs are combinational from the current inputs and registered state, so they take effect at the same edge.
- Reset:
  - While rst_n=0, all four *_clear=1 and all *_hold=0.
  - Mult/div FSM returns to IDLE; counter=0; stall_cnt=0; md_busy=0; md_done=0.
  - Reset mid-mult/div aborts the operation with no md_done pulse.
- Definitions:
  - load_use = ex_memread & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
  - md_stall = (state==IDLE & ex_md_start) | state==BUSY.
- Priority (one applies per cycle; all others' clear/hold signals are 0):
  1. mem_wait=1: all holds=1, all clears=0. Whole pipe frozen; FSM and its counter frozen.
  2. md_stall: pc/ifid/idex hold=1; exmem_clear=1 (bubble); memwb advances.
  3. load_use: pc/ifid hold=1; idex_clear=1.
  4. id_branch_taken: ifid_clear=1; nothing held.
  5. None: all outputs 0.
- id_branch_taken is ignored whenever priority 1–3 is active; the branch re-resolves after the stall.
- Mult/div FSM (IDLE, BUSY, DONE):
  - IDLE→BUSY on ex_md_start & !mem_wait; counter loads MD_CYCLES-2.
  - BUSY: counter decrements each non-mem_wait cycle; →DONE when counter==0.
  - DONE→IDLE after one non-mem_wait cycle.
  - md_busy=1 in BUSY; md_done=1 in DONE.
  - In DONE the pipe advances and ex_md_start is ignored, so the same instruction never restarts.
  - Total EX occupancy is MD_CYCLES cycles: the start cycle plus MD_CYCLES-2 BUSY cycles plus DONE.
  - A new ex_md_start is accepted only in IDLE.
- stall_cnt increments on every cycle with pc_hold=1 and rst_n=1; wraps from 0xFFFFFFFF to 0.
- Simultaneous events:
  - load_use and branch together: stall only; the branch is not flushed.
  - mem_wait during md_stall: full freeze; the mult/div counter does not advance.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → all four clears=1, holds=0, stall_cnt=0; release → all outputs 0 with idle inputs.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle → pc_hold=ifid_hold=idex_clear=1, stall_cnt=1. Repeat with ex_rt=0 → no stall.
- Branch vs load-use: id_branch_taken=1 alone → ifid_clear=1 only. Branch together with load_use (ex_rt=id_rt=9, id_uses_rt=1) → stall outputs, ifid_clear=0.
- Mult/div, MD_CYCLES=4: ex_md_start held high → pc/ifid/idex hold and exmem_clear for exactly 3 cycles; md_done=1 on the 4th cycle with holds released; no restart; stall_cnt=3.
- mem_wait inside BUSY: assert mem_wait 2 cycles mid-operation → all holds=1, clears=0; md_done delayed by exactly 2 cycles.
- Wrap and abort: force stall_cnt to 0xFFFFFFFF and stall 1 cycle → 0. Pulse rst_n low during BUSY → FSM=IDLE, no md_done.
